// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared funct codes, state encoding and sign-correction helpers
package muldiv_sequencer_pkg;
  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 6;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1a;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1b;
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_MUL = 2'd1, MD_DIV = 2'd2, MD_DONE = 2'd3} md_state_e;
  typedef logic [4:0] md_cnt_t;
  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// div_step: one restoring-division iteration on {rem, quo}
module div_step
  import muldiv_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);
  logic [DATA_W:0] shifted, diff;
  assign shifted = {rem_in, quo_in[DATA_W-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign rem_out = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_out = {quo_in[DATA_W-2:0], ~diff[DATA_W]};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-iteration multiply/divide sequencer producing a one-cycle HI/LO write
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  operand_1,
  input  logic [DATA_W-1:0]  operand_2,
  input  logic               flush,
  output logic               stall_req,
  output logic               busy,
  output logic               hilo_write_en,
  output logic [DATA_W-1:0]  hi_write_data,
  output logic [DATA_W-1:0]  lo_write_data
);
  md_state_e state_q, state_d;
  md_cnt_t cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic signed_q, signed_d, sa_q, sa_d, sb_q, sb_d;
  logic valid, is_mul, is_signed, accept;
  logic [DATA_W-1:0] abs_a, abs_b, rem_nx, quo_nx;
  logic [63:0] prod_nx, mul_res;
  assign valid     = funct == FUNCT_MULT || funct == FUNCT_MULTU || funct == FUNCT_DIV || funct == FUNCT_DIVU;
  assign is_mul    = funct == FUNCT_MULT || funct == FUNCT_MULTU;
  assign is_signed = funct == FUNCT_MULT || funct == FUNCT_DIV;
  assign accept    = state_q == MD_IDLE && start && valid && !flush;
  assign abs_a     = cond_neg32(operand_1, is_signed && operand_1[DATA_W-1]);
  assign abs_b     = cond_neg32(operand_2, is_signed && operand_2[DATA_W-1]);
  assign prod_nx   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign mul_res   = cond_neg64(prod_nx, signed_q && (sa_q ^ sb_q));
  assign stall_req     = accept || state_q == MD_MUL || state_q == MD_DIV;
  assign busy          = state_q == MD_MUL || state_q == MD_DIV;
  assign hilo_write_en = state_q == MD_DONE && !flush;
  assign hi_write_data = hi_q;
  assign lo_write_data = lo_q;
  div_step u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );
  // next-state: accept in IDLE, iterate in MUL/DIV, finalise at cnt 31; flush overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    signed_d  = signed_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    case (state_q)
      MD_IDLE: if (accept) begin
        signed_d  = is_signed;
        sa_d      = is_signed && operand_1[DATA_W-1];
        sb_d      = is_signed && operand_2[DATA_W-1];
        cnt_d     = '0;
        acc_d     = '0;
        mcand_d   = {32'd0, abs_a};
        mplier_d  = abs_b;
        rem_d     = '0;
        quo_d     = abs_a;
        divisor_d = abs_b;
        state_d   = is_mul ? MD_MUL : (operand_2 == '0 ? MD_DONE : MD_DIV);
        if (!is_mul && operand_2 == '0) begin
          hi_d = operand_1;
          lo_d = '1;
        end
      end
      MD_MUL: begin
        acc_d    = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d      = MD_DONE;
          {hi_d, lo_d} = mul_res;
        end
      end
      MD_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = MD_DONE;
          hi_d    = cond_neg32(rem_nx, signed_q && sa_q);
          lo_d    = cond_neg32(quo_nx, signed_q && (sa_q ^ sb_q));
        end
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush && state_q != MD_IDLE) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      signed_q  <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      signed_q  <= signed_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;
  logic clk, rst_n, start, flush;
  logic [5:0] funct;
  logic [31:0] operand_1, operand_2;
  logic stall_req, busy, hilo_write_en;
  logic [31:0] hi_write_data, lo_write_data;
  int n_cmp, n_fail;

  muldiv_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .funct         (funct),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .flush         (flush),
    .stall_req     (stall_req),
    .busy          (busy),
    .hilo_write_en (hilo_write_en),
    .hi_write_data (hi_write_data),
    .lo_write_data (lo_write_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // reference: {hi, lo} from plain arithmetic
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    int si_a, si_b;
    sa = $signed(a);
    sb = $signed(b);
    si_a = $signed(a);
    si_b = $signed(b);
    if (f == FUNCT_MULTU) return {32'd0, a} * {32'd0, b};
    if (f == FUNCT_MULT) begin
      sp = sa * sb;
      return sp;
    end
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (f == FUNCT_DIVU) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    return {32'(si_a % si_b), 32'(si_a / si_b)};
  endfunction

  // drive one op until its write; reports result, stall count, write cycle and write count
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int stalls, output int wr_cyc, output int writes);
    hi = 0; lo = 0; stalls = 0; wr_cyc = -1; writes = 0;
    @(negedge clk);
    start = 1; funct = f; operand_1 = a; operand_2 = b;
    for (int c = 0; c < 40; c++) begin
      if (wr_cyc >= 0) start = 0;
      #1;
      if (stall_req) stalls++;
      if (hilo_write_en) begin
        writes++;
        if (wr_cyc < 0) begin
          wr_cyc = c; hi = hi_write_data; lo = lo_write_data;
        end
      end
      @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; start = 0; flush = 0; funct = 0; operand_1 = 0; operand_2 = 0;
    #2;
    n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_req); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (hilo_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", hilo_write_en); end
    n_cmp++; if (hi_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi_write_data); end
    n_cmp++; if (lo_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo_write_data); end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_directed;
    logic [5:0] fs [7] = '{FUNCT_MULTU, FUNCT_MULT, FUNCT_MULT, FUNCT_DIV, FUNCT_DIVU, FUNCT_DIV, FUNCT_DIVU};
    logic [31:0] as [7] = '{32'hFFFFFFFF, -32'sd3, 32'h80000000, -32'sd7, 32'd100, 32'h80000000, 32'd5};
    logic [31:0] bs [7] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
    logic [31:0] eh [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5};
    logic [31:0] el [7] = '{32'h00000001, 32'hFFFFFFF1, 32'd0, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF};
    int es [7] = '{33, 33, 33, 33, 33, 33, 1};
    logic [31:0] hi, lo;
    int st, wc, wr;
    for (int i = 0; i < 7; i++) begin
      do_op(fs[i], as[i], bs[i], hi, lo, st, wc, wr);
      n_cmp++; if (hi !== eh[i]) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", i, hi, eh[i]); end
      n_cmp++; if (lo !== el[i]) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", i, lo, el[i]); end
      n_cmp++; if (st != es[i]) begin n_fail++; $display("FAIL dir%0d_stalls got %0d want %0d", i, st, es[i]); end
      n_cmp++; if (wc != es[i]) begin n_fail++; $display("FAIL dir%0d_wrcyc got %0d want %0d", i, wc, es[i]); end
      n_cmp++; if (wr != 1) begin n_fail++; $display("FAIL dir%0d_writes got %0d want 1", i, wr); end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, hi, lo;
    logic [5:0] f;
    logic [63:0] e;
    int st, wc, wr, exp_st;
    for (int i = 0; i < 24; i++) begin
      f = FUNCT_MULT + 6'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 4))
        1: b = 0;
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = $urandom_range(1, 15);
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      e = ref_md(f, a, b);
      exp_st = (f >= FUNCT_DIV && b == 0) ? 1 : 33;
      do_op(f, a, b, hi, lo, st, wc, wr);
      n_cmp++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL rnd%0d f=%h a=%h b=%h got %h_%h want %h", i, f, a, b, hi, lo, e); end
      n_cmp++; if (st != exp_st || wc != exp_st || wr != 1) begin n_fail++; $display("FAIL rnd%0d_timing stalls=%0d wrcyc=%0d writes=%0d want %0d/%0d/1", i, st, wc, wr, exp_st, exp_st); end
    end
    for (int i = 0; i < 3; i++) begin
      f = 6'h20 + 6'(i);
      do_op(f, $urandom, $urandom, hi, lo, st, wc, wr);
      n_cmp++; if (st != 0 || wr != 0) begin n_fail++; $display("FAIL invalid%0d stalls=%0d writes=%0d want 0/0", i, st, wr); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] hi, lo;
    int st, wc, wr;
    @(negedge clk);
    start = 1; funct = FUNCT_DIV; operand_1 = 32'd1000; operand_2 = 32'd7;
    for (int c = 0; c < 10; c++) @(negedge clk);
    flush = 1;
    #1;
    n_cmp++; if (hilo_write_en !== 1'b0) begin n_fail++; $display("FAIL flush_div_wen got %b want 0", hilo_write_en); end
    @(negedge clk);
    flush = 0; start = 0;
    #1;
    n_cmp++; if (busy !== 1'b0 || stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_div_idle busy=%b stall=%b want 0/0", busy, stall_req); end
    wr = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (hilo_write_en) wr++;
    end
    n_cmp++; if (wr != 0) begin n_fail++; $display("FAIL flush_div_nowrite got %0d writes want 0", wr); end
    do_op(FUNCT_DIVU, 32'd9, 32'd3, hi, lo, st, wc, wr);
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd3 || wr != 1) begin n_fail++; $display("FAIL after_flush got hi=%h lo=%h writes=%0d want 0/3/1", hi, lo, wr); end
    @(negedge clk);
    start = 1; funct = FUNCT_MULTU; operand_1 = 32'd2; operand_2 = 32'd3;
    for (int c = 0; c < 33; c++) @(negedge clk);
    flush = 1;
    #1;
    n_cmp++; if (hilo_write_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_done wen=%b busy=%b want 0/0", hilo_write_en, busy); end
    @(negedge clk);
    start = 0;
    #1;
    n_cmp++; if (hilo_write_en !== 1'b0) begin n_fail++; $display("FAIL flush_done_next wen=%b want 0", hilo_write_en); end
    start = 1; funct = FUNCT_MULTU;
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got %b want 0", stall_req); end
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy got %b want 0", busy); end
    flush = 0; start = 0;
  endtask

  task automatic test_reset_mid;
    int wr;
    @(negedge clk);
    start = 1; funct = FUNCT_MULTU; operand_1 = 32'd12345; operand_2 = 32'd678;
    for (int c = 0; c < 15; c++) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy); end
    rst_n = 0; start = 0;
    #1;
    n_cmp++; if ({stall_req, busy, hilo_write_en} !== 3'b000 || hi_write_data !== 0 || lo_write_data !== 0) begin
      n_fail++; $display("FAIL mid_reset stall=%b busy=%b wen=%b hi=%h lo=%h want all 0", stall_req, busy, hilo_write_en, hi_write_data, lo_write_data);
    end
    @(negedge clk);
    rst_n = 1;
    wr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (hilo_write_en) wr++;
    end
    n_cmp++; if (wr != 0) begin n_fail++; $display("FAIL mid_reset_nowrite got %0d writes want 0", wr); end
  endtask

  task automatic test_back_to_back;
    int wc [2];
    logic [31:0] wl [2];
    int nw;
    nw = 0; wc[0] = -1; wc[1] = -1; wl[0] = 0; wl[1] = 0;
    @(negedge clk);
    start = 1; funct = FUNCT_MULTU; operand_1 = 32'd2; operand_2 = 32'd3;
    for (int c = 0; c < 80; c++) begin
      if (nw == 1) begin operand_1 = 32'd4; operand_2 = 32'd5; end
      if (nw == 2) start = 0;
      #1;
      if (hilo_write_en && nw < 2) begin wc[nw] = c; wl[nw] = lo_write_data; nw++; end
      @(negedge clk);
    end
    start = 0;
    n_cmp++; if (nw != 2) begin n_fail++; $display("FAIL b2b_count got %0d writes want 2", nw); end
    n_cmp++; if (wl[0] !== 32'd6 || wl[1] !== 32'd20) begin n_fail++; $display("FAIL b2b_lo got %0d,%0d want 6,20", wl[0], wl[1]); end
    n_cmp++; if (wc[1] - wc[0] != 34) begin n_fail++; $display("FAIL b2b_spacing got %0d want 34", wc[1] - wc[0]); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
